// File: rtl/div_seq_radix2.sv
// div_seq_radix2: sequential radix-2 restoring divider with divw/divwu semantics.
// It produces one quotient bit per cycle. FIX takes two cycles: the sign
// correction comes first, then the overflow override, the CR compare and the
// output registers. This keeps the negation adders off the compare path and
// gives a fixed start-to-complete latency of WIDTH+3 edges.
// Optional macro DIV_SEQ_EARLY_OUT_EN: PREP jumps straight to FIX when the
// quotient is trivially zero (overflow, a==0, |a|<|b|). complete then pulses
// 3 edges after the start.
module div_seq_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             uns,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             complete,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [3:0]       crf,
    output logic             div_by_zero
);

    localparam int               CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             fix_phase;

    // Operands captured at the start edge
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic             uns_lat;

    // Working registers: dvd shifts the dividend out and the quotient in
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   prem;
    logic             q_neg;
    logic             r_neg;
    logic             ovf;
    logic             dbz;

    // Two's-complement negate when requested
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + ONE) : v;
    endfunction

    // PREP-cycle magnitude and exception terms
    logic             a_sgn;
    logic             b_sgn;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_zero;
    logic             prep_ovf;
    logic             early;

    assign a_sgn    = !uns_lat && a_lat[WIDTH-1];
    assign b_sgn    = !uns_lat && b_lat[WIDTH-1];
    assign a_mag    = cond_neg(a_lat, a_sgn);
    assign b_mag    = cond_neg(b_lat, b_sgn);
    assign b_zero   = (b_lat == '0);
    assign prep_ovf = b_zero || (!uns_lat && (a_lat == MIN_NEG) && (b_lat == '1));

`ifdef DIV_SEQ_EARLY_OUT_EN
    assign early = prep_ovf || (a_lat == '0) || (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    // Restoring step: shift in the next dividend bit, then trial-subtract
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           trial_ok;

    assign shifted  = {prem[WIDTH-1:0], dvd[WIDTH-1]};
    assign trial    = shifted - {1'b0, dsr};
    assign trial_ok = !trial[WIDTH];

    // Final quotient seen in the output cycle; overflow forces zero
    logic [WIDTH-1:0] q_out;
    logic             q_lt;
    logic             q_eq;

    assign q_out = ovf ? '0 : dvd;
    assign q_lt  = q_out[WIDTH-1];
    assign q_eq  = (q_out == '0);

    // Control FSM with registered ready/complete
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            fix_phase <= 1'b0;
            ready     <= 1'b1;
            complete  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= PREP;
                        ready <= 1'b0;
                    end
                end
                PREP: begin
                    count     <= '0;
                    fix_phase <= 1'b0;
                    state     <= early ? FIX : ITER;
                end
                ITER: begin
                    count <= count + CNT_ONE;
                    if (count == LAST) begin
                        state     <= FIX;
                        fix_phase <= 1'b0;
                    end
                end
                FIX: begin
                    if (!fix_phase) begin
                        fix_phase <= 1'b1;
                    end else begin
                        state    <= DONE;
                        complete <= 1'b1;
                        ready    <= 1'b1;
                    end
                end
                DONE: begin
                    complete <= 1'b0;
                    if (en) begin
                        state <= PREP;
                        ready <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: operand capture, magnitude load, iteration and sign correction
    always_ff @(posedge clk) begin
        case (state)
            IDLE, DONE: begin
                if (en) begin
                    a_lat   <= a;
                    b_lat   <= b;
                    uns_lat <= uns;
                end
            end
            PREP: begin
                prem  <= early ? {1'b0, a_mag} : '0;
                dvd   <= early ? '0 : a_mag;
                dsr   <= b_mag;
                q_neg <= !uns_lat && (a_lat[WIDTH-1] ^ b_lat[WIDTH-1]);
                r_neg <= a_sgn;
                ovf   <= prep_ovf;
                dbz   <= b_zero;
            end
            ITER: begin
                prem <= trial_ok ? trial : shifted;
                dvd  <= {dvd[WIDTH-2:0], trial_ok};
            end
            FIX: begin
                if (!fix_phase) begin
                    dvd  <= cond_neg(dvd, q_neg);
                    prem <= {1'b0, cond_neg(prem[WIDTH-1:0], r_neg)};
                end
            end
            default: ;
        endcase
    end

    // Result registers, updated once per operation and held until the next one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quotient    <= '0;
            remainder   <= '0;
            crf         <= 4'b0000;
            div_by_zero <= 1'b0;
        end else if (state == FIX && fix_phase) begin
            quotient    <= q_out;
            remainder   <= ovf ? '0 : prem[WIDTH-1:0];
            crf         <= {q_lt, !q_lt && !q_eq, q_eq, ovf};
            div_by_zero <= dbz;
        end
    end

endmodule

// File: tb/tb_div_seq_radix2.sv
// Testbench for div_seq_radix2: directed vectors with hand-computed results,
// a scoreboard queue filled at issue time and a monitor that checks on complete.
module tb_div_seq_radix2;

    localparam int W = 32;
`ifdef DIV_SEQ_EARLY_OUT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic         uns = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready;
    logic         complete;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic [3:0]   crf;
    logic         div_by_zero;

    div_seq_radix2 #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .uns         (uns),
        .a           (a),
        .b           (b),
        .ready       (ready),
        .complete    (complete),
        .quotient    (quotient),
        .remainder   (remainder),
        .crf         (crf),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [3:0]   crf;
        logic         dbz;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Expected start-to-complete latency in edges
    function automatic int lat(input logic [W-1:0] av, input logic [W-1:0] bv, input logic u);
        logic [W-1:0] am;
        logic [W-1:0] bm;
        logic         ov;
        logic         early;
        am    = (!u && av[W-1]) ? -av : av;
        bm    = (!u && bv[W-1]) ? -bv : bv;
        ov    = (bv == '0) || (!u && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF);
        early = ov || (av == '0) || (am < bm);
        return (EARLY_EN && early) ? 3 : W + 3;
    endfunction

    task automatic issue(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic u, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic [3:0] ec, input logic ed, input logic expect_done);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            nerr++;
            $display("FAIL %s ready: got 0 after 200 cycles, expected 1", nm);
            return;
        end
        a   = av;
        b   = bv;
        uns = u;
        en  = 1'b1;
        if (expect_done) begin
            e.name = nm;
            e.q    = eq;
            e.r    = er;
            e.crf  = ec;
            e.dbz  = ed;
            e.due  = cyc + 1 + lat(av, bv, u);
            sb.push_back(e);
        end
        nvec++;
        @(negedge clk);
        en = 1'b0;
    endtask

    // Monitor: every complete pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!reset && complete) begin
            if (sb.size() == 0) begin
                nerr++;
                $display("FAIL spurious_complete: got complete=1 at cycle %0d, expected 0", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, " quotient"}, quotient, e.q);
                chk({e.name, " remainder"}, remainder, e.r);
                chk({e.name, " crf"}, W'(crf), W'(e.crf));
                chk({e.name, " div_by_zero"}, W'(div_by_zero), W'(e.dbz));
                chk({e.name, " ready"}, W'(ready), W'(1));
                chk({e.name, " latency_cycle"}, W'(cyc), W'(e.due));
            end
        end
    end

    initial begin
        int guard;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst ready", W'(ready), W'(1));
        chk("rst complete", W'(complete), W'(0));
        chk("rst quotient", quotient, '0);
        chk("rst remainder", remainder, '0);
        chk("rst crf", W'(crf), W'(0));
        chk("rst div_by_zero", W'(div_by_zero), W'(0));
        reset = 1'b0;

        // Signed/unsigned basics; consecutive issues land in the DONE cycle
        issue("s_100_7",    32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          4'b0100, 1'b0, 1'b1);
        issue("s_m100_7",   32'hFFFF_FF9C,  32'd7,          1'b0, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  4'b1000, 1'b0, 1'b1);
        issue("s_100_m7",   32'd100,        32'hFFFF_FFF9,  1'b0, 32'hFFFF_FFF2,  32'd2,          4'b1000, 1'b0, 1'b1);
        issue("s_m100_m7",  32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b0, 32'd14,         32'hFFFF_FFFE,  4'b0100, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        issue("u_ffff_2",   32'hFFFF_FFFF,  32'd2,          1'b1, 32'h7FFF_FFFF,  32'd1,          4'b0100, 1'b0, 1'b1);
        issue("s_min_m1",   32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'd0,          4'b0011, 1'b0, 1'b1);
        issue("u_min_ffff", 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'd0,          32'h8000_0000,  4'b0010, 1'b0, 1'b1);
        issue("s_min_2",    32'h8000_0000,  32'd2,          1'b0, 32'hC000_0000,  32'd0,          4'b1000, 1'b0, 1'b1);
        issue("u_min_2",    32'h8000_0000,  32'd2,          1'b1, 32'h4000_0000,  32'd0,          4'b0100, 1'b0, 1'b1);

        // Divide by zero in both modes
        issue("s_5_0",      32'd5,          32'd0,          1'b0, 32'd0,          32'd0,          4'b0011, 1'b1, 1'b1);
        issue("u_5_0",      32'd5,          32'd0,          1'b1, 32'd0,          32'd0,          4'b0011, 1'b1, 1'b1);

        // Trivially-zero quotients (early-out candidates)
        repeat (2) @(negedge clk);
        issue("s_3_7",      32'd3,          32'd7,          1'b0, 32'd0,          32'd3,          4'b0010, 1'b0, 1'b1);
        issue("s_m7_100",   32'hFFFF_FFF9,  32'd100,        1'b0, 32'd0,          32'hFFFF_FFF9,  4'b0010, 1'b0, 1'b1);
        issue("s_0_5",      32'd0,          32'd5,          1'b0, 32'd0,          32'd0,          4'b0010, 1'b0, 1'b1);

        // en while busy is ignored: pulse at k+5 with different operands
        issue("u_1000_3",   32'd1000,       32'd3,          1'b1, 32'd333,        32'd1,          4'b0100, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        a   = 32'd77;
        b   = 32'd5;
        uns = 1'b0;
        en  = 1'b1;
        @(negedge clk);
        en  = 1'b0;
        issue("s_77_5",     32'd77,         32'd5,          1'b0, 32'd15,         32'd2,          4'b0100, 1'b0, 1'b1);

        // Reset mid-iteration discards the operation and clears outputs at once
        issue("rst_mid",    32'h1234_5678,  32'd3,          1'b1, 32'd0,          32'd0,          4'b0000, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst ready", W'(ready), W'(1));
        chk("midrst complete", W'(complete), W'(0));
        chk("midrst quotient", quotient, '0);
        chk("midrst remainder", remainder, '0);
        chk("midrst crf", W'(crf), W'(0));
        chk("midrst div_by_zero", W'(div_by_zero), W'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (45) @(negedge clk);

        // Normal operation after reset
        issue("post_rst",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          4'b0100, 1'b0, 1'b1);

        // Drain the scoreboard with a bounded wait
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL drain: got %0d results outstanding, expected 0", sb.size());
        end
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/div_seq_radix2.md
Name: div_seq_radix2

Overview:
- Sequential radix-2 restoring integer divider, one quotient bit per cycle.
- Core instantiated inside the divide functional unit. It is fed the registered enable, the signedness flag and the operand-bus A/B words.
- Produces quotient, remainder, the CR field and the overflow/divide-by-zero indications. The divide unit places these on the result bus.
- Implements divw/divwu semantics.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits. Must be ≥4 and even.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- en  input  1  start request; sampled only while ready=1
- uns  input  1  1 = unsigned divide (divwu), 0 = signed (divw); sampled with en
- a  input  WIDTH  dividend; sampled on the edge where a start is accepted
- b  input  WIDTH  divisor; sampled on the edge where a start is accepted
- ready  output  1  idle; a start will be accepted
- complete  output  1  single-cycle pulse; results valid
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- crf  output  4  CR field {lt,gt,eq,ov}
- div_by_zero  output  1  registered, b was zero for the completed operation

Behaviour:
- Reset (asynchronous, any state): state=IDLE, ready=1, complete=0, quotient/remainder/crf/div_by_zero=0. An operation in flight is discarded.
- States:
  - IDLE → PREP on en=1.
  - PREP → ITER, unconditional.
  - ITER → ITER while count<WIDTH-1.
  - ITER → FIX at count=WIDTH-1.
  - FIX → DONE.
  - DONE → IDLE, or DONE → PREP if en=1 in DONE (back-to-back issue).
- Start: en=1 with ready=1 at edge k latches a, b and uns. ready=0 from edge k until the DONE cycle.
- en while busy (PREP/ITER/FIX) is ignored and has no side effects.
- PREP:
  - Compute |a| and |b| (signed), or pass the raw values (unsigned).
  - Record the quotient sign (a_msb XOR b_msb) and the remainder sign (a_msb) when signed.
  - Detect exceptions:
    - div_by_zero = (b==0).
    - Overflow = div_by_zero OR (signed AND a==1<<(WIDTH-1) AND b==all-ones).
- ITER: WIDTH iterations.
  - Partial remainder is WIDTH+1 bits. Shift in the next dividend bit and trial-subtract the divisor.
  - If non-negative, keep the difference and set the quotient bit. Otherwise restore.
  - count is a 0..WIDTH-1 counter and resets to 0 in PREP.
- FIX:
  - Negate the quotient if its sign is set; negate the remainder if the dividend was negative (signed mode only).
  - On overflow: quotient=0, remainder=0.
  - Register the outputs.
- DONE: complete=1 for exactly one cycle, i.e. in the cycle beginning at edge k+WIDTH+3. ready=1 in DONE.
- Output hold: quotient, remainder, crf and div_by_zero hold their values until the next FIX.
- crf:
  - lt/gt/eq = signed compare of the final quotient against 0, in both modes. Overflow gives q=0, so eq=1.
  - ov = overflow flag. The summary-overflow merge is not done here; the consumer does it.
- Remainder identity: for non-overflow cases, a = q*b + r with |r|<|b|, and r has the dividend's sign (signed mode).
- Latency is fixed: WIDTH+3 edges from start to the complete pulse, independent of operands unless the optional feature is enabled.

Optional Feature:
- Macro: DIV_SEQ_EARLY_OUT_EN.
- Defined:
  - PREP branches directly to FIX when overflow, a==0, or |a|<|b| (unsigned compare of the magnitudes). The early quotient is 0 and the early remainder is a.
  - complete then pulses at edge k+3.
  - The DONE/ready rules are unchanged.
- Undefined: fixed WIDTH+3 latency for all operands; no compare logic is built.

Test Plan:
- Signed 100/7 (uns=0): en at edge k → complete at k+35, quotient=14, remainder=2, crf={0,1,0,0}, div_by_zero=0.
- Signed 0xFFFFFF9C(-100)/7 → quotient=0xFFFFFFF2, remainder=0xFFFFFFFE, crf={1,0,0,0}.
- Unsigned 0xFFFFFFFF/2 → quotient=0x7FFFFFFF, remainder=1. Signed 0x80000000/0xFFFFFFFF → quotient=0, remainder=0, crf={0,0,1,1}, div_by_zero=0.
- Divide by zero, a=5, b=0, both modes → quotient=0, crf.ov=1, div_by_zero=1, complete still at k+35.
- Busy/back-to-back:
  - en pulsed at k+5 with different operands → ignored; first result unchanged.
  - en asserted in the DONE cycle → second op accepted, complete at DONE+35.
- Reset asserted mid-ITER (k+10) → ready=1, complete=0, outputs 0 immediately, no complete pulse. With DIV_SEQ_EARLY_OUT_EN, 3/7 → quotient=0, remainder=3, complete at k+3.
